calendar_ctrl: RTL and testbench

//  Sequencer/arbiter for the date, month and year counters of the digital clock calendar.
//  - Turns the hour-rollover day tick into increment pulses for each counter.
//  - Runs the user set-mode FSM and drives the counters' load/data inputs.
//  - Owns the shared read-back databus: grants one counter's enable at a time and checks

---
 rtl/calendar_pkg.sv | 47 ++++
 rtl/calendar_ctrl_if.sv | 35 +++
 rtl/cal_bus_scan.sv | 45 ++++
 rtl/calendar_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_calendar_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared types, limits and field helpers for the calendar controller
package calendar_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_DATE  = 2'd1,
    MODE_SET_MONTH = 2'd2,
    MODE_SET_YEAR  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    SEL_DATE  = 2'd0,
    SEL_MONTH = 2'd1,
    SEL_YEAR  = 2'd2
  } field_sel_t;

  localparam int MONTHS_PY = 12;
  localparam int YEAR_MAX  = 99;
  localparam int DATE_MIN  = 1;

  // Bus scan rotation order: date -> month -> year -> date
  function automatic field_sel_t next_field(input field_sel_t f);
    case (f)
      SEL_DATE:  return SEL_MONTH;
      SEL_MONTH: return SEL_YEAR;
      default:   return SEL_DATE;
    endcase
  endfunction

  // Field edited in a given set mode (RUN maps to date, the scan's home slot)
  function automatic field_sel_t mode_field(input mode_t m);
    case (m)
      MODE_SET_MONTH: return SEL_MONTH;
      MODE_SET_YEAR:  return SEL_YEAR;
      default:        return SEL_DATE;
    endcase
  endfunction

  function automatic logic [3:0] month_inc(input logic [3:0] m);
    return (m == 4'(MONTHS_PY)) ? 4'd1 : m + 4'd1;
  endfunction

  function automatic logic [6:0] year_inc(input logic [6:0] y);
    return (y == 7'(YEAR_MAX)) ? 7'd0 : y + 7'd1;
  endfunction

endpackage

// File: rtl/calendar_ctrl_if.sv
// rtl/calendar_ctrl_if.sv - calendar controller signal bundle with controller/counter-side modports
interface calendar_ctrl_if #(
  parameter int BUS_W = 7
);
  logic             day_tick;
  logic             btn_mode;
  logic             btn_inc;
  logic [BUS_W-1:0] databus;
  logic             date_tick;
  logic             month_tick;
  logic             year_tick;
  logic             date_load;
  logic             month_load;
  logic             year_load;
  logic [BUS_W-1:0] load_data;
  logic             date_en;
  logic             month_en;
  logic             year_en;
  logic [1:0]       set_mode;
  logic             sync_err;

  modport master (
    input  day_tick, btn_mode, btn_inc, databus,
    output date_tick, month_tick, year_tick,
    output date_load, month_load, year_load, load_data,
    output date_en, month_en, year_en, set_mode, sync_err
  );

  modport slave (
    output day_tick, btn_mode, btn_inc, databus,
    input  date_tick, month_tick, year_tick,
    input  date_load, month_load, year_load, load_data,
    input  date_en, month_en, year_en, set_mode, sync_err
  );
endinterface

// File: rtl/cal_bus_scan.sv
// rtl/cal_bus_scan.sv - read-back bus slot sequencer: one-hot grant and end-of-slot sample strobe
module cal_bus_scan
  import calendar_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       lock,
  input  field_sel_t lock_sel,
  output logic [2:0] grant,
  output logic       sample_stb,
  output field_sel_t sample_sel
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  field_sel_t    slot;
  field_sel_t    gsel;

  // Slot counter; while locked it is parked so that unlocking restarts at date, count 0
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt  <= '0;
      slot <= SEL_DATE;
    end else if (lock) begin
      cnt  <= '0;
      slot <= SEL_DATE;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      slot <= next_field(slot);
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

  // Grant follows the locked field during edits, otherwise the rotating slot
  always_comb begin
    gsel       = lock ? lock_sel : slot;
    grant      = 3'b001 << gsel;
    sample_stb = !lock && (cnt == LAST);
    sample_sel = slot;
  end
endmodule

// File: rtl/calendar_ctrl.sv
// rtl/calendar_ctrl.sv - calendar sequencer: set-mode FSM, mirrors, tick/load pulses, bus check
module calendar_ctrl
  import calendar_pkg::*;
#(
  parameter int BUS_W    = 7,
  parameter int SCAN_DIV = 4,
  parameter int DAYS_PM  = 30
) (
  input  logic            clk,
  input  logic            clear,
  calendar_ctrl_if.master bus
);
  mode_t            state, state_nx;
  logic [1:0]       mode_step;
  logic [4:0]       date_m, date_nx;
  logic [3:0]       month_m, month_nx;
  logic [6:0]       year_m, year_nx;
  logic             pending_day, pend_nx;
  logic             day_ev;
  logic [2:0]       tick_q, tick_nx;   // {year, month, date}
  logic [2:0]       load_q, load_nx;   // {year, month, date}
  logic [BUS_W-1:0] load_data_q, load_data_nx;

  logic             scan_lock;
  field_sel_t       lock_sel;
  logic [2:0]       grant;
  logic             sample_stb;
  field_sel_t       sample_sel;
  logic             touch_now;
  logic             dirty;
  logic             sync_err_q;
  logic [BUS_W-1:0] mirror_sel;

  function automatic logic [4:0] date_inc(input logic [4:0] d);
    return (d == 5'(DAYS_PM)) ? 5'(DATE_MIN) : d + 5'd1;
  endfunction

  // Mode register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= MODE_RUN;
    else       state <= state_nx;
  end

  // Next mode, pending day, mirror updates and the pulses registered with them
  always_comb begin
    state_nx     = state;
    pend_nx      = pending_day;
    date_nx      = date_m;
    month_nx     = month_m;
    year_nx      = year_m;
    tick_nx      = '0;
    load_nx      = '0;
    load_data_nx = '0;
    day_ev       = 1'b0;
    mode_step    = state + 2'd1;

    if (bus.btn_mode) state_nx = mode_t'(mode_step);

    // A deferred day is released on the edge that returns to RUN, so its
    // date_tick lands in the first RUN cycle and never meets a load pulse.
    if (state == MODE_RUN) begin
      day_ev = bus.day_tick;
    end else if (state == MODE_SET_YEAR && bus.btn_mode) begin
      day_ev  = pending_day | bus.day_tick;
      pend_nx = 1'b0;
    end else if (bus.day_tick) begin
      pend_nx = 1'b1;
    end

    if (day_ev) begin
      tick_nx[0] = 1'b1;
      date_nx    = date_inc(date_m);
      if (date_m == 5'(DAYS_PM)) begin
        tick_nx[1] = 1'b1;
        month_nx   = month_inc(month_m);
        if (month_m == 4'(MONTHS_PY)) begin
          tick_nx[2] = 1'b1;
          year_nx    = year_inc(year_m);
        end
      end
    end

    // A mode step in the same cycle swallows the increment
    if (state != MODE_RUN && bus.btn_inc && !bus.btn_mode) begin
      case (state)
        MODE_SET_DATE: begin
          date_nx      = date_inc(date_m);
          load_nx[0]   = 1'b1;
          load_data_nx = BUS_W'(date_inc(date_m));
        end
        MODE_SET_MONTH: begin
          month_nx     = month_inc(month_m);
          load_nx[1]   = 1'b1;
          load_data_nx = BUS_W'(month_inc(month_m));
        end
        MODE_SET_YEAR: begin
          year_nx      = year_inc(year_m);
          load_nx[2]   = 1'b1;
          load_data_nx = BUS_W'(year_inc(year_m));
        end
        default: ;
      endcase
    end
  end

  // Mirrors and output pulses move together on the same edge
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      date_m      <= 5'(DATE_MIN);
      month_m     <= 4'd1;
      year_m      <= 7'd0;
      pending_day <= 1'b0;
      tick_q      <= '0;
      load_q      <= '0;
      load_data_q <= '0;
    end else begin
      date_m      <= date_nx;
      month_m     <= month_nx;
      year_m      <= year_nx;
      pending_day <= pend_nx;
      tick_q      <= tick_nx;
      load_q      <= load_nx;
      load_data_q <= load_data_nx;
    end
  end

  assign scan_lock = (state != MODE_RUN);
  assign lock_sel  = mode_field(state);

  cal_bus_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .clear      (clear),
    .lock       (scan_lock),
    .lock_sel   (lock_sel),
    .grant      (grant),
    .sample_stb (sample_stb),
    .sample_sel (sample_sel)
  );

  // Mirror and pulse activity of the field currently on the bus
  always_comb begin
    touch_now  = 1'b0;
    mirror_sel = '0;
    case (sample_sel)
      SEL_DATE: begin
        touch_now  = tick_q[0] | load_q[0];
        mirror_sel = BUS_W'(date_m);
      end
      SEL_MONTH: begin
        touch_now  = tick_q[1] | load_q[1];
        mirror_sel = BUS_W'(month_m);
      end
      SEL_YEAR: begin
        touch_now  = tick_q[2] | load_q[2];
        mirror_sel = BUS_W'(year_m);
      end
      default: ;
    endcase
  end

  // The counter trails the mirror by one cycle after a pulse, so a slot that
  // saw one is not trusted; otherwise any end-of-slot disagreement sticks.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      dirty      <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      if (sample_stb && !(dirty || touch_now) && (bus.databus != mirror_sel))
        sync_err_q <= 1'b1;
      if (scan_lock || sample_stb) dirty <= 1'b0;
      else                         dirty <= dirty | touch_now;
    end
  end

  assign bus.date_tick  = tick_q[0];
  assign bus.month_tick = tick_q[1];
  assign bus.year_tick  = tick_q[2];
  assign bus.date_load  = load_q[0];
  assign bus.month_load = load_q[1];
  assign bus.year_load  = load_q[2];
  assign bus.load_data  = load_data_q;
  assign bus.date_en    = grant[0];
  assign bus.month_en   = grant[1];
  assign bus.year_en    = grant[2];
  assign bus.set_mode   = state;
  assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_calendar_ctrl.sv
// tb/tb_calendar_ctrl.sv - self-checking bench for calendar_ctrl with behavioural model
module tb_calendar_ctrl;
  localparam int BUS_W    = 7;
  localparam int SCAN_DIV = 4;
  localparam int DAYS_PM  = 30;

  logic clk = 1'b0;
  logic clear;

  calendar_ctrl_if #(.BUS_W(BUS_W)) bus ();

  calendar_ctrl #(
    .BUS_W    (BUS_W),
    .SCAN_DIV (SCAN_DIV),
    .DAYS_PM  (DAYS_PM)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_dt = 0, n_mt = 0, n_yt = 0;

  // ---------------- counter emulation driving the read-back bus ----------------
  logic [4:0]       c_date;
  logic [3:0]       c_month;
  logic [6:0]       c_year;
  logic             bus_ovr;
  logic [BUS_W-1:0] ovr_val;

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      c_date  <= 5'd1;
      c_month <= 4'd1;
      c_year  <= 7'd0;
    end else begin
      if (bus.date_load)      c_date <= bus.load_data[4:0];
      else if (bus.date_tick) c_date <= (c_date == 5'd30) ? 5'd1 : c_date + 5'd1;
      if (bus.month_load)      c_month <= bus.load_data[3:0];
      else if (bus.month_tick) c_month <= (c_month == 4'd12) ? 4'd1 : c_month + 4'd1;
      if (bus.year_load)      c_year <= bus.load_data[6:0];
      else if (bus.year_tick) c_year <= (c_year == 7'd99) ? 7'd0 : c_year + 7'd1;
    end
  end

  assign bus.databus = bus_ovr      ? ovr_val :
                       bus.date_en  ? {2'b00, c_date} :
                       bus.month_en ? {3'b000, c_month} : c_year;

  // ---------------- behavioural model ----------------
  int mm, md, mmo, my, run_cnt, cyc, e_ld;
  int touch [3];
  bit mpend, e_dt, e_mt, e_yt, e_dl, e_ml, e_yl, e_err;
  logic [BUS_W-1:0] bus_seen;

  function automatic int exp_field();
    if (mm != 0) return mm - 1;
    return (run_cnt / SCAN_DIV) % 3;
  endfunction

  task automatic model_reset();
    mm = 0; md = 1; mmo = 1; my = 0; mpend = 0;
    run_cnt = 0; cyc = 0; e_ld = 0;
    e_dt = 0; e_mt = 0; e_yt = 0; e_dl = 0; e_ml = 0; e_yl = 0; e_err = 0;
    for (int i = 0; i < 3; i++) touch[i] = -1000;
  endtask

  task automatic model_step();
    int f, slot_start, mir, nm;
    bit dayev;
    if (e_dt || e_dl) touch[0] = cyc;
    if (e_mt || e_ml) touch[1] = cyc;
    if (e_yt || e_yl) touch[2] = cyc;
    if (mm == 0 && (run_cnt % SCAN_DIV) == SCAN_DIV - 1) begin
      f = exp_field();
      slot_start = cyc - (run_cnt % SCAN_DIV);
      mir = (f == 0) ? md : (f == 1) ? mmo : my;
      if (touch[f] < slot_start && int'(bus_seen) != mir) e_err = 1;
    end
    e_dt = 0; e_mt = 0; e_yt = 0; e_dl = 0; e_ml = 0; e_yl = 0; e_ld = 0;
    dayev = 0;
    if (mm == 0) dayev = bus.day_tick;
    else if (mm == 3 && bus.btn_mode) begin
      dayev = mpend || bus.day_tick;
      mpend = 0;
    end else if (bus.day_tick) mpend = 1;
    if (dayev) begin
      e_dt = 1;
      if (md == DAYS_PM) begin
        md = 1; e_mt = 1;
        if (mmo == 12) begin
          mmo = 1; e_yt = 1; my = (my + 1) % 100;
        end else mmo = mmo + 1;
      end else md = md + 1;
    end
    if (mm != 0 && bus.btn_inc && !bus.btn_mode) begin
      case (mm)
        1: begin md  = md % DAYS_PM + 1; e_dl = 1; e_ld = md;  end
        2: begin mmo = mmo % 12 + 1;     e_ml = 1; e_ld = mmo; end
        default: begin my = (my + 1) % 100; e_yl = 1; e_ld = my; end
      endcase
    end
    nm = bus.btn_mode ? (mm + 1) % 4 : mm;
    run_cnt = (mm == 0 && nm == 0) ? run_cnt + 1 : 0;
    mm = nm;
    cyc = cyc + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge clear);
      if (clear) model_reset();
      else       model_step();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    int f;
    forever begin
      @(negedge clk);
      bus_seen = bus.databus;
      if (bus.date_tick)  n_dt++;
      if (bus.month_tick) n_mt++;
      if (bus.year_tick)  n_yt++;
      f = exp_field();
      chk("date_tick",  int'(bus.date_tick),  int'(e_dt));
      chk("month_tick", int'(bus.month_tick), int'(e_mt));
      chk("year_tick",  int'(bus.year_tick),  int'(e_yt));
      chk("date_load",  int'(bus.date_load),  int'(e_dl));
      chk("month_load", int'(bus.month_load), int'(e_ml));
      chk("year_load",  int'(bus.year_load),  int'(e_yl));
      if (e_dl || e_ml || e_yl) chk("load_data", int'(bus.load_data), e_ld);
      chk("date_en",  int'(bus.date_en),  int'(f == 0));
      chk("month_en", int'(bus.month_en), int'(f == 1));
      chk("year_en",  int'(bus.year_en),  int'(f == 2));
      chk("set_mode", int'(bus.set_mode), mm);
      chk("sync_err", int'(bus.sync_err), int'(e_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_day();
    step(); bus.day_tick = 1'b1; step(); bus.day_tick = 1'b0;
  endtask

  task automatic do_mode();
    step(); bus.btn_mode = 1'b1; step(); bus.btn_mode = 1'b0;
  endtask

  task automatic do_inc();
    step(); bus.btn_inc = 1'b1; step(); bus.btn_inc = 1'b0;
  endtask

  initial begin
    int k0, m0;
    bit found;
    clear = 1'b1;
    bus.day_tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    bus_ovr = 1'b0; ovr_val = '0;
    repeat (3) step();
    chk("rst_date_en",   int'(bus.date_en),   1);
    chk("rst_month_en",  int'(bus.month_en),  0);
    chk("rst_set_mode",  int'(bus.set_mode),  0);
    chk("rst_sync_err",  int'(bus.sync_err),  0);
    chk("rst_load_data", int'(bus.load_data), 0);
    chk("rst_date_tick", int'(bus.date_tick), 0);
    clear = 1'b0;
    step();

    // three day ticks from reset
    k0 = n_dt; m0 = n_mt;
    do_day();
    chk("t1_latency", int'(bus.date_tick), 1);
    do_day(); do_day();
    repeat (3) step();
    chk("t1_count", n_dt - k0, 3);
    chk("t1_no_month", n_mt - m0, 0);
    chk("t1_model_date", md, 4);

    // set 30/12/99 then roll everything over
    do_mode(); repeat (26) do_inc();
    do_mode(); repeat (11) do_inc();
    do_mode(); repeat (99) do_inc();
    do_mode();
    chk("t2_model_set", md * 10000 + mmo * 100 + my, 301299);
    repeat (5) step();
    do_day();
    chk("t2_date_tick",  int'(bus.date_tick),  1);
    chk("t2_month_tick", int'(bus.month_tick), 1);
    chk("t2_year_tick",  int'(bus.year_tick),  1);
    chk("t2_model_wrap", md * 10000 + mmo * 100 + my, 10100);
    repeat (3) step();

    // date edit 29 -> 30 -> 1
    do_mode(); repeat (28) do_inc();
    do_inc();
    chk("t3_load30", int'(bus.load_data), 30);
    chk("t3_dload",  int'(bus.date_load), 1);
    chk("t3_en",     int'(bus.date_en),   1);
    do_inc();
    chk("t3_load1",  int'(bus.load_data), 1);
    chk("t3_en2",    int'(bus.date_en),   1);

    // mode and inc together: mode wins
    step(); bus.btn_mode = 1'b1; bus.btn_inc = 1'b1;
    step(); bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    chk("t4_mode", int'(bus.set_mode), 2);
    chk("t4_noload", int'(bus.date_load), 0);

    // pending day collapses to one tick on the first RUN cycle
    k0 = n_dt;
    do_day(); do_day();
    do_mode();
    chk("t5_set_year", int'(bus.set_mode), 3);
    do_mode();
    chk("t5_run", int'(bus.set_mode), 0);
    chk("t5_first_tick", int'(bus.date_tick), 1);
    repeat (3) step();
    chk("t5_count", n_dt - k0, 1);
    chk("t5_model_date", md, 2);

    // clean scan, then corrupt the month slot
    repeat (30) step();
    chk("t6_clean", int'(bus.sync_err), 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.month_en) found = 1;
    end
    chk("t6_month_slot_found", int'(found), 1);
    if (found) begin
      bus_ovr = 1'b1; ovr_val = 7'd5;
      for (int i = 0; i < 2 * SCAN_DIV && bus.month_en; i++) step();
      bus_ovr = 1'b0;
    end
    repeat (3) step();
    chk("t6_err_set", int'(bus.sync_err), 1);
    repeat (20) step();
    chk("t6_err_sticky", int'(bus.sync_err), 1);

    // clear in the middle of a year edit
    do_mode(); do_mode(); do_mode();
    do_inc();
    chk("t7_yload", int'(bus.year_load), 1);
    chk("t7_ydata", int'(bus.load_data), 1);
    step(); clear = 1'b1;
    step();
    chk("t7_rst_mode", int'(bus.set_mode), 0);
    chk("t7_rst_en",   int'(bus.date_en),  1);
    chk("t7_rst_err",  int'(bus.sync_err), 0);
    chk("t7_model",    md * 10000 + mmo * 100 + my, 10100);
    clear = 1'b0;
    do_mode(); do_mode(); do_mode();
    do_inc();
    chk("t7_year_restart", int'(bus.load_data), 1);
    chk("t7_yload2", int'(bus.year_load), 1);
    do_mode();
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
